seq_divider: RTL and testbench

- Sequential signed divider: the inverse datapath of the Booth multiplier loop.
- Takes an M-bit dividend and an N-bit divisor and produces an M-bit quotient and an N-bit remainder.
- Uses a restoring shift/subtract algorithm, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit and shares its start/done handshake style.

---
 rtl/seq_divider_pkg.sv | 19 +
 rtl/seq_divider_step.sv | 25 ++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encodings are fixed so they read the same in waveforms and on debug buses.
package seq_divider_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude, keep or restore the remainder and shift in the quotient bit.
module div_step #(
  parameter int M = 32,
  parameter int N = 32
) (
  input  logic [N:0]   i_rem,
  input  logic [M-1:0] i_quo,
  input  logic [N-1:0] i_dvs,
  output logic [N:0]   o_rem,
  output logic [M-1:0] o_quo
);

  logic [N+1:0] w_sh_rem;
  logic [N:0]   w_diff;
  logic         w_lt;

  assign w_sh_rem = {i_rem, i_quo[M-1]};
  assign w_lt     = (w_sh_rem < {2'b00, i_dvs});
  assign w_diff   = w_sh_rem[N:0] - {1'b0, i_dvs};

  assign o_rem = w_lt ? w_sh_rem[N:0] : w_diff;
  assign o_quo = {i_quo[M-2:0], ~w_lt};

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: magnitudes are divided one quotient bit per clock,
// then signs are applied in a single fixup cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int M = 32,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] Reg_dividend,
  input  logic [N-1:0] Reg_divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] Reg_quotient,
  output logic [N-1:0] Reg_remainder,
  output logic         div_zero,
  output logic         overflow
);

  localparam int CW = cnt_width(M);

  state_t         r_state, w_next;
  logic [M-1:0]   r_dividend, r_quo, w_quo_nx;
  logic [N-1:0]   r_divisor, r_dvs_mag;
  logic [N:0]     r_rem, w_rem_nx;
  logic [CW-1:0]  r_cnt;
  logic           r_sign_q, r_sign_r, r_dz, r_ovf, r_done;
  logic [N-1:0]   w_rem_mag;

  div_step #(.M(M), .N(N)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs_mag),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  assign w_rem_mag = r_rem[N-1:0];
  assign busy      = (r_state == ST_INIT) || (r_state == ST_ITER) || (r_state == ST_FIX);
  assign done      = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_INIT;
      ST_INIT:          w_next = (r_divisor == '0) ? ST_FIX : ST_ITER;
      ST_ITER:          if (r_cnt == CW'(1)) w_next = ST_FIX;
      ST_FIX:           w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_dvs_mag     <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_ovf         <= 1'b0;
      r_done        <= 1'b0;
      Reg_quotient  <= '0;
      Reg_remainder <= '0;
      div_zero      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_dividend <= Reg_dividend;
            r_divisor  <= Reg_divisor;
            div_zero   <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        ST_INIT: begin
          r_dvs_mag <= r_divisor[N-1] ? -r_divisor : r_divisor;
          r_quo     <= r_dividend[M-1] ? -r_dividend : r_dividend;
          r_rem     <= '0;
          r_cnt     <= CW'(M);
          r_sign_q  <= r_dividend[M-1] ^ r_divisor[N-1];
          r_sign_r  <= r_dividend[M-1];
          r_dz      <= (r_divisor == '0);
          // The wrapped quotient already comes out of the magnitude path; only the flag needs decoding.
          r_ovf     <= (M == N) && (r_dividend == {1'b1, {(M-1){1'b0}}}) && (r_divisor == '1);
        end
        ST_ITER: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          if (r_dz) begin
            Reg_quotient  <= '1;
            Reg_remainder <= r_dividend[N-1:0];
            div_zero      <= 1'b1;
          end else begin
            Reg_quotient  <= r_sign_q ? -r_quo : r_quo;
            Reg_remainder <= r_sign_r ? -w_rem_mag : w_rem_mag;
            overflow      <= r_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results are queued at start and
// compared when done pulses, along with latency, busy and result-hold behaviour.
module tb_seq_divider;

  localparam int M = 32;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] Reg_dividend = '0;
  logic [N-1:0] Reg_divisor = '0;
  logic         busy, done, div_zero, overflow;
  logic [M-1:0] Reg_quotient;
  logic [N-1:0] Reg_remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nassert = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          s0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_divider #(.M(M), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .Reg_dividend  (Reg_dividend),
    .Reg_divisor   (Reg_divisor),
    .busy          (busy),
    .done          (done),
    .Reg_quotient  (Reg_quotient),
    .Reg_remainder (Reg_remainder),
    .div_zero      (div_zero),
    .overflow      (overflow)
  );

  function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
    exp_t e;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.lat = M + 3;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 3;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      e.q = 32'h8000_0000; e.r = '0; e.ov = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int t0);
    @(negedge clk);
    Reg_dividend = a;
    Reg_divisor  = b;
    start        = 1'b1;
    t0           = cyc;
    sb.push_back(model(a, b));
  endtask

  // Runs one operation to its done pulse; optionally pulses a second start at cycle inj_k.
  task automatic run_op(input int inj_k, input logic [31:0] ia, input logic [31:0] ib);
    exp_t e;
    bit   got = 1'b0;
    int   lat;
    if (sb.size() == 0) begin
      nassert++; nfail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e   = sb.pop_front();
    lat = e.lat;
    for (int k = 1; k <= lat + 2 && !got; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (inj_k != 0 && k == inj_k) begin
        Reg_dividend = ia; Reg_divisor = ib; start = 1'b1;
      end
      if (inj_k != 0 && k == inj_k + 1) start = 1'b0;
      if (done) begin
        got = 1'b1;
        check("done_latency", 32'(k), 32'(lat));
        check("quotient", Reg_quotient, e.q);
        check("remainder", Reg_remainder, e.r);
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("busy_at_done", 32'(busy), 32'd0);
        last_q = e.q;
        last_r = e.r;
      end else begin
        check("busy", 32'(busy), 32'(k < lat));
        check("held_quotient", Reg_quotient, last_q);
        check("held_remainder", Reg_remainder, last_r);
        check("flags_cleared", {30'd0, div_zero, overflow}, 32'd0);
      end
    end
    if (!got) begin
      nassert++; nfail++;
      $error("FAIL done_timeout: observed no done expected done at cycle %0d", lat);
    end
  endtask

  initial begin
    bit saw_done;

    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", Reg_quotient, 32'd0);
    check("rst_remainder", Reg_remainder, 32'd0);
    check("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start_op(32'd100, 32'd7, s0);
    run_op(0, '0, '0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_hold_q", Reg_quotient, 32'd14);

    start_op(32'hFFFF_FF9C, 32'd7, s0);
    run_op(0, '0, '0);
    start_op(32'd100, 32'hFFFF_FFF9, s0);
    run_op(0, '0, '0);
    start_op(32'd7, 32'd0, s0);
    run_op(0, '0, '0);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, s0);
    run_op(0, '0, '0);
    start_op(32'd0, 32'd5, s0);
    run_op(0, '0, '0);
    start_op(32'h8000_0000, 32'd7, s0);
    run_op(0, '0, '0);
    start_op(32'h7FFF_FFFF, 32'h8000_0000, s0);
    run_op(0, '0, '0);

    start_op(32'd100, 32'd7, s0);
    run_op(10, 32'd50, 32'd5);
    start_op(32'd50, 32'd5, s0);
    run_op(0, '0, '0);

    start_op(32'hFFFF_FF9C, 32'd7, s0);
    run_op(0, '0, '0);
    start_op(32'd100, 32'd7, s0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    void'(sb.pop_back());
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", Reg_quotient, 32'd0);
    check("abort_remainder", Reg_remainder, 32'd0);
    check("abort_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    start_op(32'd9, 32'd3, s0);
    run_op(0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
